pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central hazard/stall scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Arbitrates four hazard sources by fixed priority: D-cache miss, multi-cycle multiply, taken branch, load-use.
- Drives per-stage register enables, flush/bubble strobes and PC hold.
- Sits beside the pipeline register block and replaces the ad-hoc control bits fed to it.

Parameters:
- REG_ADDR_W, 5, register index width.
- MUL_LAT, 4, EX-stage multiply latency in cycles (legal values ≥1; 1 = no stall).
- CNT_W, 32, performance counter width (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- id_rs1  in  REG_ADDR_W  ID-stage source register 1
- id_rs2  in  REG_ADDR_W  ID-stage source register 2
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_valid  in  1  EX stage holds a real instruction
- ex_rd  in  REG_ADDR_W  EX destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_mul_start  in  1  EX instruction is a multiply
- ex_branch_taken  in  1  branch resolved taken in EX
- dcache_miss  in  1  MEM access not satisfied this cycle
- dcache_ready  in  1  refill complete; MEM data valid
- if_en, id_en, ex_en, mem_en, wb_en  out  1 each  stage register load enables (IF/ID, ID/EX, EX/MEM, MEM/WB, regfile write qualifier)
- pc_hold  out  1  PC does not advance
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load NOP into ID/EX
- ex_mem_bubble  out  1  load NOP into EX/MEM
- mem_wb_bubble  out  1  load NOP into MEM/WB
- state  out  2  0=RUN, 1=DC_WAIT, 2=MUL_BUSY
- perf_clr  in  1  synchronous clear of counters
- perf_dc, perf_mul, perf_lu, perf_br  out  CNT_W each  event counters

Behaviour:
- Reset is asynchronous and active-high; clock is clock.
- During reset: state=RUN, mul counter=0, all enables 0, all flush/bubble 0, pc_hold=0.
- Outputs are combinational from state and inputs. State and counter are registered.
- Default RUN outputs: all enables 1, strobes 0, pc_hold 0.
- Priority, evaluated in RUN (first match wins):
  - P1 dcache_miss=1: if/id/ex/mem_en=0, pc_hold=1, mem_wb_bubble=1, wb_en=1. Next state DC_WAIT.
  - P2 ex_valid & ex_mul_start & MUL_LAT>1: if/id/ex_en=0, pc_hold=1, ex_mem_bubble=1. mem_en and wb_en stay 1. Load counter with MUL_LAT-2. Next state MUL_BUSY.
  - P3 ex_valid & ex_branch_taken: if_id_flush=1, id_ex_flush=1. All enables 1. pc_hold=0, since fetch takes the redirect.
  - P4 load-use: ex_valid & ex_mem_read & ex_rd≠0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)). Then if_en=id_en=0, pc_hold=1, id_ex_flush=1. ex/mem/wb_en=1.
- ex_mul_start with ex_branch_taken together is illegal; P2 wins.
- DC_WAIT:
  - While dcache_ready=0: outputs as in P1.
  - In the cycle dcache_ready=1: outputs are evaluated as RUN with the dcache_miss input ignored (P2–P4 still apply). Next state is RUN, or MUL_BUSY if P2 fired.
- MUL_BUSY:
  - While counter≠0: outputs as in P2 and the counter decrements.
  - When counter==0: outputs are evaluated as RUN with P2 suppressed. Next state RUN.
  - dcache_miss=1 in MUL_BUSY (older instruction in MEM) takes P1 outputs. The counter pauses, state remains MUL_BUSY, and the freeze holds until dcache_ready.
- Total EX occupancy for a multiply is exactly MUL_LAT cycles, excluding D-cache pause cycles.
- Reset asserted mid-DC_WAIT or mid-MUL_BUSY returns immediately to RUN with counter 0.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined: four saturating CNT_W counters, reset to 0, cleared by perf_clr (perf_clr wins over increment).
  - perf_dc +1 per cycle with P1 outputs.
  - perf_mul +1 per cycle with P2 outputs.
  - perf_br +1 per P3 cycle.
  - perf_lu +1 per P4 cycle.
- Undefined: counter logic is absent, the perf_* outputs are tied to 0, and perf_clr is ignored.

Test Plan:
- Reset held 3 cycles, then released with no hazards → during reset all enables 0; after release if_en..wb_en=1, state=0.
- Load in EX with ex_rd=5, ID has id_rs2=5 and id_rs2_used=1 → one cycle of if_en=id_en=0, pc_hold=1, id_ex_flush=1; next cycle (ex_mem_read=0) all enables 1.
- ex_branch_taken=1 together with a load-use condition → if_id_flush=id_ex_flush=1, if_en=1, pc_hold=0 (branch beats load-use).
- ex_mul_start=1, MUL_LAT=4 → exactly 3 cycles with ex_en=0 and ex_mem_bubble=1, then release; with MUL_LAT=1 → no stall.
- dcache_miss=1 for 1 cycle, then dcache_ready after 5 DC_WAIT cycles → mem_en=0 for 6 cycles, mem_wb_bubble=1, state=1; RUN in the ready cycle.
- Multiply in MUL_BUSY with dcache_miss injected at counter=1 for 2 cycles → counter holds at 1, then finishes; with HAZ_PERF_CNT_EN, perf_mul=3 and perf_dc=2.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: hazard sources from ID/EX/MEM and the stage
// control strobes returned to the pipeline register block.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    // hazard sources
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_mul_start;
    logic                  ex_branch_taken;
    logic                  dcache_miss;
    logic                  dcache_ready;
    logic                  perf_clr;

    // stage controls
    logic                  if_en;
    logic                  id_en;
    logic                  ex_en;
    logic                  mem_en;
    logic                  wb_en;
    logic                  pc_hold;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_bubble;
    logic                  mem_wb_bubble;
    logic [1:0]            state;
    logic [CNT_W-1:0]      perf_dc;
    logic [CNT_W-1:0]      perf_mul;
    logic [CNT_W-1:0]      perf_lu;
    logic [CNT_W-1:0]      perf_br;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_valid, ex_rd,
               ex_mem_read, ex_mul_start, ex_branch_taken, dcache_miss,
               dcache_ready, perf_clr,
        input  if_en, id_en, ex_en, mem_en, wb_en, pc_hold, if_id_flush,
               id_ex_flush, ex_mem_bubble, mem_wb_bubble, state,
               perf_dc, perf_mul, perf_lu, perf_br
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_valid, ex_rd,
               ex_mem_read, ex_mul_start, ex_branch_taken, dcache_miss,
               dcache_ready, perf_clr,
        output if_en, id_en, ex_en, mem_en, wb_en, pc_hold, if_id_flush,
               id_ex_flush, ex_mem_bubble, mem_wb_bubble, state,
               perf_dc, perf_mul, perf_lu, perf_br
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/stall scheduler for the 5-stage pipeline.
// Fixed priority: D-cache miss > multi-cycle multiply > taken branch > load-use.
// Stage controls are combinational from state and inputs; state, multiply
// counter and D-cache freeze flag are registered.
// Optional macro HAZ_PERF_CNT_EN adds saturating hazard event counters;
// without it the perf_* outputs are tied to zero and perf_clr is ignored.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_LAT    = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    pipe_hazard_ctrl_if.slave bus
);
    // counter holds MUL_LAT-2 at most
    localparam int MC_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [MC_W-1:0] MUL_LOAD =
        (MUL_LAT > 1) ? MC_W'(MUL_LAT - 2) : {MC_W{1'b0}};
    localparam logic MUL_STALLS = (MUL_LAT > 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DC_WAIT  = 2'd1,
        ST_MUL_BUSY = 2'd2
    } state_t;

    state_t          state_r, state_next_s;
    logic [MC_W-1:0] cnt_r, cnt_next_s;
    logic            frz_r, frz_next_s;   // miss seen in MUL_BUSY, waiting on refill

    logic mul_hit_s, br_hit_s, lu_hit_s;
    logic p1_s, p2_s, p3_s, p4_s;
    logic run_eval_s, allow_mul_s;

    // hazard detection on the raw pipeline inputs
    always_comb begin
        mul_hit_s = bus.ex_valid & bus.ex_mul_start & MUL_STALLS;
        br_hit_s  = bus.ex_valid & bus.ex_branch_taken;
        lu_hit_s  = bus.ex_valid & bus.ex_mem_read &
                    (bus.ex_rd != {REG_ADDR_W{1'b0}}) &
                    ((bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd)) |
                     (bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd)));
    end

    // next-state logic and selection of the active hazard response
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        frz_next_s   = frz_r;
        run_eval_s   = 1'b0;
        allow_mul_s  = 1'b0;
        p1_s         = 1'b0;
        p2_s         = 1'b0;
        p3_s         = 1'b0;
        p4_s         = 1'b0;

        case (state_r)
            ST_RUN: begin
                if (bus.dcache_miss) begin
                    p1_s         = 1'b1;
                    state_next_s = ST_DC_WAIT;
                end else begin
                    run_eval_s  = 1'b1;
                    allow_mul_s = 1'b1;
                end
            end
            ST_DC_WAIT: begin
                if (!bus.dcache_ready) begin
                    p1_s = 1'b1;
                end else begin
                    // refill cycle: miss input ignored, the rest as RUN
                    run_eval_s   = 1'b1;
                    allow_mul_s  = 1'b1;
                    state_next_s = ST_RUN;
                end
            end
            ST_MUL_BUSY: begin
                if (bus.dcache_miss || (frz_r && !bus.dcache_ready)) begin
                    // older instruction stuck in MEM: freeze, counter paused
                    p1_s       = 1'b1;
                    frz_next_s = 1'b1;
                end else if (cnt_r != {MC_W{1'b0}}) begin
                    p2_s       = 1'b1;
                    frz_next_s = 1'b0;
                    cnt_next_s = cnt_r - MC_W'(1);
                end else begin
                    // final multiply cycle: the result leaves EX now
                    frz_next_s   = 1'b0;
                    run_eval_s   = 1'b1;
                    allow_mul_s  = 1'b0;
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_RUN;
                cnt_next_s   = {MC_W{1'b0}};
                frz_next_s   = 1'b0;
            end
        endcase

        if (run_eval_s) begin
            if (allow_mul_s && mul_hit_s) begin
                p2_s         = 1'b1;
                cnt_next_s   = MUL_LOAD;
                state_next_s = ST_MUL_BUSY;
            end else if (br_hit_s) begin
                p3_s = 1'b1;
            end else if (lu_hit_s) begin
                p4_s = 1'b1;
            end else begin
                p3_s = 1'b0;
            end
        end else begin
            run_eval_s = 1'b0;
        end
    end

    // state, multiply counter and freeze flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
            cnt_r   <= {MC_W{1'b0}};
            frz_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            frz_r   <= frz_next_s;
        end
    end

    // stage enables and strobes decoded from the selected hazard response
    always_comb begin
        bus.if_en         = 1'b1;
        bus.id_en         = 1'b1;
        bus.ex_en         = 1'b1;
        bus.mem_en        = 1'b1;
        bus.wb_en         = 1'b1;
        bus.pc_hold       = 1'b0;
        bus.if_id_flush   = 1'b0;
        bus.id_ex_flush   = 1'b0;
        bus.ex_mem_bubble = 1'b0;
        bus.mem_wb_bubble = 1'b0;
        bus.state         = state_r;

        if (reset) begin
            bus.if_en  = 1'b0;
            bus.id_en  = 1'b0;
            bus.ex_en  = 1'b0;
            bus.mem_en = 1'b0;
            bus.wb_en  = 1'b0;
        end else if (p1_s) begin
            bus.if_en         = 1'b0;
            bus.id_en         = 1'b0;
            bus.ex_en         = 1'b0;
            bus.mem_en        = 1'b0;
            bus.pc_hold       = 1'b1;
            bus.mem_wb_bubble = 1'b1;
        end else if (p2_s) begin
            bus.if_en         = 1'b0;
            bus.id_en         = 1'b0;
            bus.ex_en         = 1'b0;
            bus.pc_hold       = 1'b1;
            bus.ex_mem_bubble = 1'b1;
        end else if (p3_s) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (p4_s) begin
            bus.if_en       = 1'b0;
            bus.id_en       = 1'b0;
            bus.pc_hold     = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else begin
            bus.pc_hold = 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_dc_r, perf_mul_r, perf_lu_r, perf_br_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic hit);
        if (hit && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end else begin
            return v;
        end
    endfunction

    // saturating hazard event counters; clear beats increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_dc_r  <= {CNT_W{1'b0}};
            perf_mul_r <= {CNT_W{1'b0}};
            perf_lu_r  <= {CNT_W{1'b0}};
            perf_br_r  <= {CNT_W{1'b0}};
        end else if (bus.perf_clr) begin
            perf_dc_r  <= {CNT_W{1'b0}};
            perf_mul_r <= {CNT_W{1'b0}};
            perf_lu_r  <= {CNT_W{1'b0}};
            perf_br_r  <= {CNT_W{1'b0}};
        end else begin
            perf_dc_r  <= sat_inc(perf_dc_r,  p1_s);
            perf_mul_r <= sat_inc(perf_mul_r, p2_s);
            perf_lu_r  <= sat_inc(perf_lu_r,  p4_s);
            perf_br_r  <= sat_inc(perf_br_r,  p3_s);
        end
    end

    assign bus.perf_dc  = perf_dc_r;
    assign bus.perf_mul = perf_mul_r;
    assign bus.perf_lu  = perf_lu_r;
    assign bus.perf_br  = perf_br_r;
`else
    assign bus.perf_dc  = {CNT_W{1'b0}};
    assign bus.perf_mul = {CNT_W{1'b0}};
    assign bus.perf_lu  = {CNT_W{1'b0}};
    assign bus.perf_br  = {CNT_W{1'b0}};
`endif

endmodule
